// File: rtl/ps2_key_lanes_if.sv
// Byte-stream, judge-control and lane-status bundle of the PS/2 key-lane decoder.
// The master drives bytes and judge requests. The slave (the decoder) returns lane and judge status.
interface ps2_key_lanes_if #(
  parameter int unsigned NUM_LANES = 4
);
  logic [7:0]           received_data;
  logic                 received_data_en;
  logic                 judge_arm;
  logic [NUM_LANES-1:0] judge_mask;
  logic [NUM_LANES-1:0] key_held;
  logic [NUM_LANES-1:0] press_pulse;
  logic [NUM_LANES-1:0] release_pulse;
  logic [7:0]           last_code;
  logic                 last_ext;
  logic                 last_break;
  logic                 judge_busy;
  logic                 judge_done;
  logic                 judge_hit;

  modport master (
    output received_data, received_data_en, judge_arm, judge_mask,
    input  key_held, press_pulse, release_pulse, last_code, last_ext, last_break,
    input  judge_busy, judge_done, judge_hit
  );

  modport slave (
    input  received_data, received_data_en, judge_arm, judge_mask,
    output key_held, press_pulse, release_pulse, last_code, last_ext, last_break,
    output judge_busy, judge_done, judge_hit
  );
endinterface

// File: rtl/ps2_key_lanes.sv
// PS/2 scan-code decoder. It handles the E0 and F0 prefixes and tracks the state of NUM_LANES keys.
// It also contains an armed judge that scores the first lane press against an expected lane mask.
module ps2_key_lanes #(
  parameter int unsigned                 NUM_LANES       = 4,
  // Lane i occupies bits [8i+7:8i]: lane 0 = 74, lane 1 = 72, lane 2 = 75, lane 3 = 6B
  parameter logic [8*NUM_LANES-1:0]      LANE_CODES      = {8'h6B, 8'h75, 8'h72, 8'h74},
  parameter logic [NUM_LANES-1:0]        LANE_EXT        = '1,
  parameter bit                          SUPPRESS_REPEAT = 1'b1,
  parameter int unsigned                 PREFIX_TIMEOUT  = 1_000_000,
  parameter int unsigned                 JUDGE_WINDOW    = 25_000_000
) (
  input  logic                  clock,
  input  logic                  resetn,
  ps2_key_lanes_if.slave        lanes
);

  localparam int unsigned PW = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT + 1) : 1;
  localparam int unsigned JW = (JUDGE_WINDOW > 1) ? $clog2(JUDGE_WINDOW + 1) : 1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StExt    = 2'd1;
  localparam logic [1:0] StBrk    = 2'd2;
  localparam logic [1:0] StExtBrk = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [PW-1:0]        pf_cnt_q, pf_cnt_d;
  logic [7:0]           data;
  logic                 strobe;
  logic                 is_prefix, is_ignored;
  logic                 complete, code_ext, code_brk;

  logic [NUM_LANES-1:0] held_q, held_d;
  logic [NUM_LANES-1:0] press_q, press_d;
  logic [NUM_LANES-1:0] rel_q, rel_d;
  logic [7:0]           code_q;
  logic                 ext_q, brk_q;

  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 hit_q, hit_d;
  logic [NUM_LANES-1:0] mask_q, mask_d;
  logic [JW-1:0]        win_q, win_d;

  assign data       = lanes.received_data;
  assign strobe     = lanes.received_data_en;
  assign is_prefix  = (data == 8'hE0) || (data == 8'hF0);
  assign is_ignored = (data == 8'hFA) || (data == 8'hAA) || (data == 8'hFE) ||
                      (data == 8'hEE) || (data == 8'h00) || (data == 8'hFF);

  // Prefix decoder. A strobe is always consumed and takes priority over the timeout.
  always_comb begin
    state_d  = state_q;
    pf_cnt_d = pf_cnt_q;
    complete = 1'b0;
    code_ext = 1'b0;
    code_brk = 1'b0;
    if (strobe) begin
      pf_cnt_d = '0;
      case (state_q)
        StIdle: begin
          if (data == 8'hE0)      state_d = StExt;
          else if (data == 8'hF0) state_d = StBrk;
          else if (!is_ignored)   complete = 1'b1;
        end
        StExt: begin
          if (data == 8'hF0) begin
            state_d = StExtBrk;
          end else if (data != 8'hE0) begin
            state_d  = StIdle;
            complete = 1'b1;
            code_ext = 1'b1;
          end
        end
        StBrk: begin
          state_d  = StIdle;
          complete = !is_prefix;
          code_brk = 1'b1;
        end
        default: begin
          state_d  = StIdle;
          complete = !is_prefix;
          code_ext = 1'b1;
          code_brk = 1'b1;
        end
      endcase
    end else if ((state_q != StIdle) && (PREFIX_TIMEOUT != 0)) begin
      if (pf_cnt_q == PW'(PREFIX_TIMEOUT - 1)) begin
        state_d  = StIdle;
        pf_cnt_d = '0;
      end else begin
        pf_cnt_d = pf_cnt_q + PW'(1);
      end
    end
  end

  always_comb begin
    held_d  = held_q;
    press_d = '0;
    rel_d   = '0;
    for (int i = 0; i < int'(NUM_LANES); i++) begin
      if (complete && (data == LANE_CODES[8*i +: 8]) && (code_ext == LANE_EXT[i])) begin
        if (!code_brk) begin
          press_d[i] = !(SUPPRESS_REPEAT && held_q[i]);
          held_d[i]  = 1'b1;
        end else begin
          rel_d[i]  = held_q[i];
          held_d[i] = 1'b0;
        end
      end
    end
  end

  // The judge looks at the registered press pulse. An arm request always overrides a pending verdict.
  always_comb begin
    busy_d = busy_q;
    mask_d = mask_q;
    hit_d  = hit_q;
    win_d  = win_q;
    done_d = 1'b0;
    if (lanes.judge_arm) begin
      busy_d = 1'b1;
      mask_d = lanes.judge_mask;
      hit_d  = 1'b0;
      win_d  = '0;
    end else if (busy_q) begin
      if (|press_q) begin
        done_d = 1'b1;
        hit_d  = |(press_q & mask_q);
        busy_d = 1'b0;
      end else if ((JUDGE_WINDOW != 0) && (win_q == JW'(JUDGE_WINDOW - 1))) begin
        done_d = 1'b1;
        hit_d  = 1'b0;
        busy_d = 1'b0;
      end else if (JUDGE_WINDOW != 0) begin
        win_d = win_q + JW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      pf_cnt_q <= '0;
      held_q   <= '0;
      press_q  <= '0;
      rel_q    <= '0;
      code_q   <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hit_q    <= 1'b0;
      mask_q   <= '0;
      win_q    <= '0;
    end else begin
      state_q  <= state_d;
      pf_cnt_q <= pf_cnt_d;
      held_q   <= held_d;
      press_q  <= press_d;
      rel_q    <= rel_d;
      if (complete) begin
        code_q <= data;
        ext_q  <= code_ext;
        brk_q  <= code_brk;
      end
      busy_q <= busy_d;
      done_q <= done_d;
      hit_q  <= hit_d;
      mask_q <= mask_d;
      win_q  <= win_d;
    end
  end

  assign lanes.key_held      = held_q;
  assign lanes.press_pulse   = press_q;
  assign lanes.release_pulse = rel_q;
  assign lanes.last_code     = code_q;
  assign lanes.last_ext      = ext_q;
  assign lanes.last_break    = brk_q;
  assign lanes.judge_busy    = busy_q;
  assign lanes.judge_done    = done_q;
  assign lanes.judge_hit     = hit_q;

endmodule
